// File: rtl/morse_seq_ctrl.sv
// Morse timing sequencer: accepts a character code, strobes the codifier, and keys the returned pattern.
// Optional abort input is enabled by defining MORSE_SEQ_ABORT_EN.
module morse_seq_ctrl #(
    parameter int unsigned UNIT_CYCLES    = 4,
    parameter int unsigned DASH_UNITS     = 3,
    parameter int unsigned ELEM_GAP_UNITS = 1,
    parameter int unsigned CHAR_GAP_UNITS = 3
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [5:0] num,
    input  logic       num_valid,
    output logic       num_ready,
    output logic [5:0] cod_num,
    output logic       cod_ready,
    input  logic [4:0] cod_morse,
    input  logic [4:0] cod_display,
    output logic       key,
    output logic       elem_dash,
    output logic       busy,
    output logic       done,
    output logic       err
`ifdef MORSE_SEQ_ABORT_EN
    ,
    input  logic       abort
`endif
);

    localparam int unsigned MAX_UNITS =
        (DASH_UNITS >= CHAR_GAP_UNITS)
            ? ((DASH_UNITS >= ELEM_GAP_UNITS) ? DASH_UNITS : ELEM_GAP_UNITS)
            : ((CHAR_GAP_UNITS >= ELEM_GAP_UNITS) ? CHAR_GAP_UNITS : ELEM_GAP_UNITS);
    localparam int unsigned CNT_W = $clog2(MAX_UNITS * UNIT_CYCLES + 1);

    localparam logic [CNT_W-1:0] DOT_LD  = CNT_W'(UNIT_CYCLES - 1);
    localparam logic [CNT_W-1:0] DASH_LD = CNT_W'(DASH_UNITS * UNIT_CYCLES - 1);
    localparam logic [CNT_W-1:0] EGAP_LD = CNT_W'(ELEM_GAP_UNITS * UNIT_CYCLES - 1);
    localparam logic [CNT_W-1:0] CGAP_LD = CNT_W'(CHAR_GAP_UNITS * UNIT_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_MARK,
        S_SPACE,
        S_CGAP
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [4:0]       pend_q, pend_d;
    logic [4:0]       type_q, type_d;
    logic             dash_q, dash_d;
    logic [5:0]       cod_num_q, cod_num_d;
    logic             err_q, err_d;

    function automatic logic [2:0] top_slot(input logic [4:0] m);
        logic [2:0] res;
        res = '0;
        for (int unsigned i = 0; i < 5; i++) begin
            if (m[i]) res = 3'(i);
        end
        return res;
    endfunction

    logic [4:0] pick_src;
    logic [4:0] pick_type;
    logic [2:0] slot;

    // LOAD picks from the fresh codifier pattern, SPACE from the latched one.
    always_comb begin
        pick_src  = (state_q == S_LOAD) ? cod_display : pend_q;
        pick_type = (state_q == S_LOAD) ? cod_morse   : type_q;
        slot      = top_slot(pick_src);
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        pend_d    = pend_q;
        type_d    = type_q;
        dash_d    = dash_q;
        cod_num_d = cod_num_q;
        err_d     = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (num_valid) begin
                    if (num > 6'd35) begin
                        err_d = 1'b1;
                    end else begin
                        cod_num_d = num;
                        state_d   = S_LOAD;
                    end
                end
            end
            S_LOAD: begin
                type_d = cod_morse;
                if (cod_display == '0) begin
                    err_d   = 1'b1;
                    pend_d  = '0;
                    state_d = S_IDLE;
                end else begin
                    pend_d  = cod_display & ~(5'b00001 << slot);
                    dash_d  = pick_type[slot];
                    cnt_d   = pick_type[slot] ? DASH_LD : DOT_LD;
                    state_d = S_MARK;
                end
            end
            S_MARK: begin
                if (cnt_q == '0) begin
                    if (pend_q != '0) begin
                        cnt_d   = EGAP_LD;
                        state_d = S_SPACE;
                    end else begin
                        cnt_d   = CGAP_LD;
                        state_d = S_CGAP;
                    end
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            S_SPACE: begin
                if (cnt_q == '0) begin
                    pend_d  = pend_q & ~(5'b00001 << slot);
                    dash_d  = pick_type[slot];
                    cnt_d   = pick_type[slot] ? DASH_LD : DOT_LD;
                    state_d = S_MARK;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            S_CGAP: begin
                if (cnt_q == '0) begin
                    state_d = S_IDLE;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

`ifdef MORSE_SEQ_ABORT_EN
        if (abort && (state_q != S_IDLE)) begin
            state_d = S_IDLE;
            cnt_d   = '0;
            pend_d  = '0;
            err_d   = 1'b0;
        end
`endif
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            pend_q    <= '0;
            type_q    <= '0;
            dash_q    <= 1'b0;
            cod_num_q <= '0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            pend_q    <= pend_d;
            type_q    <= type_d;
            dash_q    <= dash_d;
            cod_num_q <= cod_num_d;
            err_q     <= err_d;
        end
    end

    assign num_ready = (state_q == S_IDLE);
    assign cod_ready = (state_q == S_LOAD);
    assign cod_num   = cod_num_q;
    assign key       = (state_q == S_MARK);
    assign elem_dash = (state_q == S_MARK) && dash_q;
    assign busy      = (state_q != S_IDLE);
    assign done      = (state_q == S_CGAP) && (cnt_q == '0);
    assign err       = err_q;

endmodule

// File: tb/tb_morse_seq_ctrl.sv
// Randomized self-checking bench for morse_seq_ctrl with a table-driven codifier and timeline model.
// Abort scenario is exercised only when MORSE_SEQ_ABORT_EN is defined.
module tb_morse_seq_ctrl;

    localparam int unsigned U  = 2;
    localparam int unsigned DU = 3;
    localparam int unsigned EG = 1;
    localparam int unsigned CG = 3;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic [5:0] num = '0;
    logic       num_valid = 1'b0;
    logic       num_ready;
    logic [5:0] cod_num;
    logic       cod_ready;
    logic [4:0] cod_morse;
    logic [4:0] cod_display;
    logic       key;
    logic       elem_dash;
    logic       busy;
    logic       done;
    logic       err;
`ifdef MORSE_SEQ_ABORT_EN
    logic       abort = 1'b0;
`endif

    int checks   = 0;
    int failures = 0;

    morse_seq_ctrl #(
        .UNIT_CYCLES(U),
        .DASH_UNITS(DU),
        .ELEM_GAP_UNITS(EG),
        .CHAR_GAP_UNITS(CG)
    ) dut (
        .clk(clk),
        .reset_n(reset_n),
        .num(num),
        .num_valid(num_valid),
        .num_ready(num_ready),
        .cod_num(cod_num),
        .cod_ready(cod_ready),
        .cod_morse(cod_morse),
        .cod_display(cod_display),
        .key(key),
        .elem_dash(elem_dash),
        .busy(busy),
        .done(done),
        .err(err)
`ifdef MORSE_SEQ_ABORT_EN
        ,
        .abort(abort)
`endif
    );

    always #5 clk = ~clk;

    string mstr [36] = '{
        "-----", ".----", "..---", "...--", "....-", ".....", "-....", "--...", "---..", "----.",
        ".-", "-...", "-.-.", "-..", ".", "..-.", "--.", "....", "..", ".---", "-.-", ".-..",
        "--", "-.", "---", ".--.", "--.-", ".-.", "...", "-", "..-", "...-", ".--", "-..-",
        "-.--", "--.."
    };
    logic [4:0] tbl_m [36];
    logic [4:0] tbl_d [36];

    // Behavioural codifier: right-aligned pattern, first element in the highest used slot.
    logic       ov_en = 1'b0;
    logic       corrupt = 1'b0;
    logic [4:0] ov_morse = '0;
    logic [4:0] ov_disp = '0;
    logic [5:0] last_code = '0;

    always_comb begin
        cod_morse   = '0;
        cod_display = '0;
        if (ov_en) begin
            cod_morse   = ov_morse;
            cod_display = ov_disp;
        end else if (int'(cod_num) < 36) begin
            cod_morse   = tbl_m[int'(cod_num)];
            cod_display = tbl_d[int'(cod_num)];
        end
        if (corrupt) begin
            cod_morse   = ~cod_morse;
            cod_display = ~cod_display;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic play(input logic [5:0] code, input bit ovr, input logic [4:0] m,
                        input logic [4:0] d);
        logic [4:0] em, ed;
        bit         ek[$];
        bit         edsh[$];
        bit         edn[$];
        int         elems[$];
        int         len;
        ov_en    = ovr;
        ov_morse = m;
        ov_disp  = d;
        corrupt  = 1'b0;
        em = ovr ? m : tbl_m[int'(code)];
        ed = ovr ? d : tbl_d[int'(code)];

        check("idle_ready", 32'(num_ready), 1);
        num       = code;
        num_valid = 1'b1;
        step();
        last_code = code;
        num_valid = 1'b0;
        num       = 6'($urandom);
        check("load_cod_ready", 32'(cod_ready), 1);
        check("load_cod_num", 32'(cod_num), 32'(code));
        check("load_busy", 32'(busy), 1);
        check("load_num_ready", 32'(num_ready), 0);
        check("load_key", 32'(key), 0);
        step();
        corrupt = 1'b1;

        if (ed == '0) begin
            check("empty_err", 32'(err), 1);
            check("empty_busy", 32'(busy), 0);
            check("empty_ready", 32'(num_ready), 1);
            check("empty_key", 32'(key), 0);
            step();
            check("empty_err_clear", 32'(err), 0);
            corrupt = 1'b0;
            return;
        end

        for (int b = 4; b >= 0; b--) begin
            if (ed[b]) elems.push_back(b);
        end
        foreach (elems[e]) begin
            len = em[elems[e]] ? int'(DU * U) : int'(U);
            for (int c = 0; c < len; c++) begin
                ek.push_back(1'b1);
                edsh.push_back(em[elems[e]]);
                edn.push_back(1'b0);
            end
            if (e != elems.size() - 1) begin
                for (int c = 0; c < int'(EG * U); c++) begin
                    ek.push_back(1'b0);
                    edsh.push_back(1'b0);
                    edn.push_back(1'b0);
                end
            end
        end
        for (int c = 0; c < int'(CG * U); c++) begin
            ek.push_back(1'b0);
            edsh.push_back(1'b0);
            edn.push_back(c == int'(CG * U) - 1);
        end

        foreach (ek[i]) begin
            check("key", 32'(key), 32'(ek[i]));
            check("elem_dash", 32'(elem_dash), 32'(edsh[i]));
            check("done", 32'(done), 32'(edn[i]));
            check("busy", 32'(busy), 1);
            check("cod_ready_low", 32'(cod_ready), 0);
            check("num_ready_low", 32'(num_ready), 0);
            if (i == 0) check("no_err", 32'(err), 0);
            num_valid = (i < ek.size() - 1) ? 1'($urandom) : 1'b0;
            num       = 6'($urandom);
            step();
        end
        num_valid = 1'b0;
        check("end_busy", 32'(busy), 0);
        check("end_ready", 32'(num_ready), 1);
        check("end_done", 32'(done), 0);
        check("end_key", 32'(key), 0);
        corrupt = 1'b0;
    endtask

    task automatic bad_code(input logic [5:0] code);
        check("bad_idle_ready", 32'(num_ready), 1);
        num       = code;
        num_valid = 1'b1;
        step();
        num_valid = 1'b0;
        check("bad_err", 32'(err), 1);
        check("bad_cod_ready", 32'(cod_ready), 0);
        check("bad_num_ready", 32'(num_ready), 1);
        check("bad_key", 32'(key), 0);
        check("bad_cod_num", 32'(cod_num), 32'(last_code));
        step();
        check("bad_err_clear", 32'(err), 0);
        check("bad_cod_ready2", 32'(cod_ready), 0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        bit seen;
        for (int c = 0; c < 36; c++) begin
            string s;
            int    n;
            logic [4:0] mm, dd;
            s  = mstr[c];
            n  = s.len();
            mm = '0;
            dd = '0;
            for (int i = 0; i < n; i++) begin
                dd[n - 1 - i] = 1'b1;
                mm[n - 1 - i] = (s[i] == 8'h2d);
            end
            tbl_m[c] = mm;
            tbl_d[c] = dd;
        end

        step();
        check("rst_key", 32'(key), 0);
        check("rst_elem_dash", 32'(elem_dash), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_done", 32'(done), 0);
        check("rst_err", 32'(err), 0);
        check("rst_cod_num", 32'(cod_num), 0);
        check("rst_cod_ready", 32'(cod_ready), 0);
        check("rst_num_ready", 32'(num_ready), 1);
        reset_n = 1'b1;
        step();

        play(6'd14, 1'b0, '0, '0);
        play(6'd10, 1'b0, '0, '0);
        play(6'd0, 1'b0, '0, '0);
        bad_code(6'd40);
        bad_code(6'd36);
        play(6'd5, 1'b1, 5'b10101, 5'b00000);
        play(6'd35, 1'b0, '0, '0);
        play(6'd7, 1'b1, 5'b01001, 5'b10110);

        // Reset in the middle of the dash of 'A'.
        ov_en     = 1'b0;
        corrupt   = 1'b0;
        num       = 6'd10;
        num_valid = 1'b1;
        step();
        num_valid = 1'b0;
        seen = 1'b0;
        for (int c = 0; c < 40 && !seen; c++) begin
            if (elem_dash) seen = 1'b1;
            else step();
        end
        check("dash_seen", 32'(seen), 1);
        step();
        #2;
        reset_n = 1'b0;
        #1;
        check("arst_key", 32'(key), 0);
        check("arst_elem_dash", 32'(elem_dash), 0);
        check("arst_busy", 32'(busy), 0);
        check("arst_num_ready", 32'(num_ready), 1);
        check("arst_cod_num", 32'(cod_num), 0);
        last_code = '0;
        step();
        reset_n = 1'b1;
        step();
        play(6'd10, 1'b0, '0, '0);

`ifdef MORSE_SEQ_ABORT_EN
        begin
            int rises;
            logic prev;
            num       = 6'd10;
            num_valid = 1'b1;
            step();
            num_valid = 1'b0;
            rises = 0;
            prev  = 1'b0;
            for (int c = 0; c < 40 && rises < 2; c++) begin
                if (key && !prev) rises++;
                prev = key;
                if (rises < 2) step();
            end
            check("abort_second_mark", 32'(rises), 2);
            abort = 1'b1;
            step();
            abort = 1'b0;
            check("abort_key", 32'(key), 0);
            check("abort_busy", 32'(busy), 0);
            check("abort_done", 32'(done), 0);
            check("abort_ready", 32'(num_ready), 1);
            last_code = 6'd10;
            abort = 1'b1;
            step();
            abort = 1'b0;
            check("abort_idle_noeffect", 32'(num_ready), 1);
            play(6'd14, 1'b0, '0, '0);
        end
`endif

        for (int r = 0; r < 24; r++) begin
            int sel;
            sel = int'($urandom_range(0, 9));
            if (sel < 6) begin
                play(6'($urandom_range(0, 35)), 1'b0, '0, '0);
            end else if (sel < 9) begin
                play(6'($urandom_range(0, 35)), 1'b1, 5'($urandom), 5'($urandom));
            end else begin
                bad_code(6'($urandom_range(36, 63)));
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
